// File: rtl/redmule_pkg.sv
// redmule_pkg: types shared between the Z drain buffer and redmule_ctrl
package redmule_pkg;

    typedef struct packed {
        logic full;
        logic empty;
    } z_buffer_flgs_t;

endpackage

// File: rtl/redmule_z_drain.sv
// redmule_z_drain: buffers up to Height result rows per tile, then streams them out in order
module redmule_z_drain
    import redmule_pkg::*;
#(
    parameter int unsigned Width  = 8,
    parameter int unsigned Height = 4,
    parameter int unsigned DataW  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         clk_en_i,
    input  logic                         fill_i,
    input  logic [Width*DataW-1:0]       z_i,
    input  logic [$clog2(Height+1)-1:0]  store_rows_i,
    output logic [Width*DataW-1:0]       z_o,
    output logic                         z_valid_o,
    input  logic                         z_ready_i,
    output z_buffer_flgs_t               flgs_o,
    output logic                         overflow_o
);

    localparam int unsigned RW = $clog2(Height+1);
    localparam int unsigned PW = Height > 1 ? $clog2(Height) : 1;
    localparam int unsigned ZW = Width*DataW;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

    state_e        state_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [RW-1:0] rows_q, rows_d;
    logic          overflow_q;
    logic [ZW-1:0] row_q [Height];
    logic          fill_en, acc, hs, last_wr, last_rd;

    always_comb begin
        fill_en = fill_i && clk_en_i;
        acc     = fill_en && state_q != DRAIN;
        hs      = state_q == DRAIN && z_ready_i;
        // The tile length is sampled only on the first fill; afterwards the latched value rules
        rows_d  = state_q != IDLE ? rows_q : store_rows_i == '0 ? RW'(Height) : store_rows_i;
        last_wr = acc && RW'(wr_ptr_q) == rows_d - RW'(1);
        last_rd = hs && RW'(rd_ptr_q) == rows_q - RW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rows_q     <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rows_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (acc) begin
                rows_q   <= rows_d;
                wr_ptr_q <= last_wr ? wr_ptr_q : wr_ptr_q + PW'(1);
                state_q  <= last_wr ? DRAIN : FILL;
            end
            if (hs) begin
                rd_ptr_q <= last_rd ? '0 : rd_ptr_q + PW'(1);
                if (last_rd) begin
                    wr_ptr_q <= '0;
                    state_q  <= IDLE;
                end
            end
            if (fill_en && state_q == DRAIN) overflow_q <= 1'b1;
        end
    end

    // Row data survives a soft clear; only a hard reset zeroes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Height; i++) row_q[i] <= '0;
        end else if (!clear_i && acc) begin
            row_q[wr_ptr_q] <= z_i;
        end
    end

    assign z_valid_o  = state_q == DRAIN;
    assign z_o        = z_valid_o ? row_q[rd_ptr_q] : '0;
    assign flgs_o     = '{full: state_q == DRAIN, empty: state_q == IDLE};
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_redmule_z_drain.sv
// tb_redmule_z_drain: directed vector table, async reset sequence, then random traffic against a queue model
module tb_redmule_z_drain;
    import redmule_pkg::*;

    localparam int H  = 4;
    localparam int ZW = 8*16;
    localparam logic [ZW-1:0] RA = 128'h3c00_3c01_3c02_3c03_3c04_3c05_3c06_3c07;
    localparam logic [ZW-1:0] RB = 128'h4000_4001_4002_4003_4004_4005_4006_4007;
    localparam logic [ZW-1:0] RC = 128'h4200_4201_4202_4203_4204_4205_4206_4207;
    localparam logic [ZW-1:0] RD = 128'h4400_4401_4402_4403_4404_4405_4406_4407;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           clr = 1'b0, en = 1'b0, fl = 1'b0, rdy = 1'b0;
    logic [ZW-1:0]  zi = '0;
    logic [2:0]     rows = '0;
    logic [ZW-1:0]  zo;
    logic           zv, ovf;
    z_buffer_flgs_t flg;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    redmule_z_drain #(.Width(8), .Height(H), .DataW(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .clk_en_i(en), .fill_i(fl),
        .z_i(zi), .store_rows_i(rows), .z_o(zo), .z_valid_o(zv), .z_ready_i(rdy),
        .flgs_o(flg), .overflow_o(ovf)
    );

    typedef struct {
        logic          clr, en, fill;
        logic [ZW-1:0] z;
        logic [2:0]    rows;
        logic          rdy, v;
        logic [ZW-1:0] ez;
        logic          full, empty, ovf;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic c, logic e, logic f, logic [ZW-1:0] z, logic [2:0] r, logic y,
                                logic v, logic [ZW-1:0] ez, logic fu, logic em, logic o);
        vec_t t;
        t.clr = c; t.en = e; t.fill = f; t.z = z; t.rows = r; t.rdy = y;
        t.v = v; t.ez = ez; t.full = fu; t.empty = em; t.ovf = o;
        tv.push_back(t);
    endfunction

    task automatic chk(string nm, logic [ZW-1:0] a, logic [ZW-1:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic chk_all(string tag, logic v, logic [ZW-1:0] ez, logic fu, logic em, logic o);
        chk({tag, " valid"}, ZW'(zv), ZW'(v));
        chk({tag, " z"}, zo, ez);
        chk({tag, " full"}, ZW'(flg.full), ZW'(fu));
        chk({tag, " empty"}, ZW'(flg.empty), ZW'(em));
        chk({tag, " ovf"}, ZW'(ovf), ZW'(o));
    endtask

    task automatic cyc(logic c, logic e, logic f, logic [ZW-1:0] z, logic [2:0] r, logic y);
        clr = c; en = e; fl = f; zi = z; rows = r; rdy = y;
        @(posedge clk); #1;
    endtask

    int            mode, n;
    logic [ZW-1:0] q[$];
    logic          movf, ev;
    logic [ZW-1:0] ez;

    initial begin
        // full tile
        add(0,1,1,RA,0,1, 0,0,0,1,0);
        add(0,1,1,RB,0,1, 0,0,0,0,0);
        add(0,1,1,RC,0,1, 0,0,0,0,0);
        add(0,1,1,RD,0,1, 0,0,0,0,0);
        add(0,1,0,0,0,1, 1,RA,1,0,0);
        add(0,1,0,0,0,1, 1,RB,1,0,0);
        add(0,1,0,0,0,1, 1,RC,1,0,0);
        add(0,1,0,0,0,1, 1,RD,1,0,0);
        // backpressure at row B
        add(0,1,1,RA,0,1, 0,0,0,1,0);
        add(0,1,1,RB,0,1, 0,0,0,0,0);
        add(0,1,1,RC,0,1, 0,0,0,0,0);
        add(0,1,1,RD,0,1, 0,0,0,0,0);
        add(0,1,0,0,0,1, 1,RA,1,0,0);
        add(0,1,0,0,0,0, 1,RB,1,0,0);
        add(0,1,0,0,0,0, 1,RB,1,0,0);
        add(0,1,0,0,0,0, 1,RB,1,0,0);
        add(0,1,0,0,0,1, 1,RB,1,0,0);
        add(0,1,0,0,0,1, 1,RC,1,0,0);
        add(0,1,0,0,0,1, 1,RD,1,0,0);
        // leftover 2-row tile, then a 1-row tile
        add(0,1,1,RA,2,1, 0,0,0,1,0);
        add(0,1,1,RB,0,1, 0,0,0,0,0);
        add(0,1,0,0,0,1, 1,RA,1,0,0);
        add(0,1,0,0,0,1, 1,RB,1,0,0);
        add(0,1,1,RC,1,1, 0,0,0,1,0);
        add(0,1,0,0,0,1, 1,RC,1,0,0);
        // gating and overflow
        add(0,0,1,RD,2,1, 0,0,0,1,0);
        add(0,1,1,RA,2,1, 0,0,0,1,0);
        add(0,0,1,RD,0,1, 0,0,0,0,0);
        add(0,1,1,RB,0,1, 0,0,0,0,0);
        add(0,1,1,RD,0,0, 1,RA,1,0,0);
        add(0,1,0,0,0,1, 1,RA,1,0,1);
        add(0,1,0,0,0,1, 1,RB,1,0,1);
        add(0,1,0,0,0,1, 0,0,0,1,1);
        // clear mid-drain, then a fresh tile
        add(0,1,1,RA,0,1, 0,0,0,1,1);
        add(0,1,1,RB,0,1, 0,0,0,0,1);
        add(0,1,1,RC,0,1, 0,0,0,0,1);
        add(0,1,1,RD,0,1, 0,0,0,0,1);
        add(0,1,1,RD,0,1, 1,RA,1,0,1);
        add(1,1,0,0,0,0, 1,RB,1,0,1);
        add(0,1,1,RD,0,1, 0,0,0,1,0);
        add(0,1,1,RC,0,1, 0,0,0,0,0);
        add(0,1,1,RB,0,1, 0,0,0,0,0);
        add(0,1,1,RA,0,1, 0,0,0,0,0);
        add(0,1,0,0,0,1, 1,RD,1,0,0);
        add(0,1,0,0,0,1, 1,RC,1,0,0);
        add(0,1,0,0,0,1, 1,RB,1,0,0);
        add(0,1,0,0,0,1, 1,RA,1,0,0);
        add(0,1,0,0,0,1, 0,0,0,1,0);

        #1;
        chk_all("reset", 0, '0, 0, 1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tv[i]) begin
            clr = tv[i].clr; en = tv[i].en; fl = tv[i].fill; zi = tv[i].z; rows = tv[i].rows; rdy = tv[i].rdy;
            chk_all($sformatf("vec%0d", i), tv[i].v, tv[i].ez, tv[i].full, tv[i].empty, tv[i].ovf);
            @(posedge clk); #1;
        end

        // async reset while filling, with overflow left sticky from the previous tile
        cyc(0,1,1,RA,0,1); cyc(0,1,1,RB,0,1); cyc(0,1,1,RC,0,1); cyc(0,1,1,RD,0,1);
        cyc(0,1,1,RD,0,1); cyc(0,1,0,0,0,1); cyc(0,1,0,0,0,1); cyc(0,1,0,0,0,1);
        cyc(0,1,1,RA,0,1); cyc(0,1,1,RB,0,1);
        fl = 1'b0;
        chk_all("pre-rst", 0, '0, 0, 0, 1);
        #3 rst_n = 1'b0;
        #1 chk_all("async-rst", 0, '0, 0, 1, 0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_all($sformatf("post-rst%0d", k), 0, '0, 0, 1, 0);
        end

        mode = 0; movf = 1'b0; q.delete(); n = 0;
        for (int k = 0; k < 3000; k++) begin
            clr  = $urandom_range(0, 99) < 2;
            en   = $urandom_range(0, 9) < 8;
            fl   = $urandom_range(0, 1) == 1;
            zi   = {$urandom(), $urandom(), $urandom(), $urandom()};
            rows = 3'($urandom_range(0, 4));
            rdy  = $urandom_range(0, 9) < 7;
            ev = mode == 2;
            ez = ev ? q[0] : '0;
            chk_all($sformatf("rnd%0d", k), ev, ez, ev, mode == 0, movf);
            if (clr) begin
                mode = 0; q.delete(); movf = 1'b0;
            end else if (mode != 2) begin
                if (fl && en) begin
                    if (mode == 0) n = rows == 0 ? H : int'(rows);
                    q.push_back(zi);
                    mode = q.size() == n ? 2 : 1;
                end
            end else begin
                if (fl && en) movf = 1'b1;
                if (rdy) begin
                    void'(q.pop_front());
                    if (q.size() == 0) mode = 0;
                end
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
